operand_forward_unit: RTL and testbench

//  - Parametrised forwarding and hazard unit for the EX stage of the RISC-V pipeline.
//  - Tracks destination tags of the instructions in MEM and WB internally.

---
 rtl/operand_forward_unit.sv | 201 ++++++++++++++++++++
 tb/tb_operand_forward_unit.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_forward_unit.sv
// rtl/operand_forward_unit.sv - EX-stage operand forwarding and load-use stall/flush unit
//
// Purpose:
//   Tracks the destination tags of the instructions in MEM and WB, forwards
//   MEM/WB results onto NUM_SRC execute operands, and detects load-use
//   hazards, driving a LOAD_LAT-cycle stall/flush sequence.
//
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   rs_addr_d      DECODE source register addresses (operand i at [i*REG_AW +: REG_AW])
//   rs_addr_e      EXECUTE source register addresses
//   rf_data_e      register-file read data in EXECUTE
//   rd_e           EXECUTE destination register
//   regwrite_e     EXECUTE writes rd_e
//   memread_e      EXECUTE instruction is a load
//   fu_result_m    MEM-stage functional-unit result
//   result_w       WB-stage final result
//   operand_e      forwarded operands
//   fwd_sel_e      per operand: 00 = RF, 01 = WB, 10 = MEM
//   stall_f        hold the PC
//   stall_d        hold the IF/ID register
//   flush_e        insert a bubble into ID/EX
//   fwd_count      cycles with any forward active (statistics build only)
//   stall_count    cycles with stall_f asserted (statistics build only)
//
// Configuration macro:
//   FWD_STATS_EN   builds saturating fwd_count/stall_count; otherwise both read 0.

module operand_forward_unit #(
    parameter int XLEN     = 32,
    parameter int NUM_SRC  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_SRC*REG_AW-1:0] rs_addr_d,
    input  logic [NUM_SRC*REG_AW-1:0] rs_addr_e,
    input  logic [NUM_SRC*XLEN-1:0]   rf_data_e,
    input  logic [REG_AW-1:0]         rd_e,
    input  logic                      regwrite_e,
    input  logic                      memread_e,
    input  logic [XLEN-1:0]           fu_result_m,
    input  logic [XLEN-1:0]           result_w,
    output logic [NUM_SRC*XLEN-1:0]   operand_e,
    output logic [NUM_SRC*2-1:0]      fwd_sel_e,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_e,
    output logic [31:0]               fwd_count,
    output logic [31:0]               stall_count
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    // Tag pipeline
    logic [REG_AW-1:0] rd_m_q, rd_m_d;
    logic              regwrite_m_q, regwrite_m_d;
    logic              memread_m_q, memread_m_d;
    logic [REG_AW-1:0] rd_w_q, rd_w_d;
    logic              regwrite_w_q, regwrite_w_d;

    // Stall FSM
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              haz;
    logic              stall_active;

    // memread_m is carried along with the MEM tags but no current logic reads it.
    logic              unused_memread_m;
    assign unused_memread_m = memread_m_q;

    // Forward select and operand mux; MEM is checked first so it wins over WB.
    always_comb begin
        fwd_sel_e = '0;
        operand_e = rf_data_e;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (regwrite_m_q && (rd_m_q != '0) &&
                (rd_m_q == rs_addr_e[i*REG_AW +: REG_AW])) begin
                fwd_sel_e[i*2 +: 2]       = 2'b10;
                operand_e[i*XLEN +: XLEN] = fu_result_m;
            end else if (regwrite_w_q && (rd_w_q != '0) &&
                         (rd_w_q == rs_addr_e[i*REG_AW +: REG_AW])) begin
                fwd_sel_e[i*2 +: 2]       = 2'b01;
                operand_e[i*XLEN +: XLEN] = result_w;
            end
        end
    end

    // Load-use: the load in EXECUTE writes a register DECODE is about to read.
    always_comb begin
        haz = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_addr_d[i*REG_AW +: REG_AW] == rd_e) begin
                haz = 1'b1;
            end
        end
        haz = haz && memread_e && (rd_e != '0);
    end

    // The first stall cycle is raised combinationally from haz; the FSM only
    // covers the remaining LOAD_LAT-1 cycles, during which EXECUTE is a bubble.
    assign stall_active = (state_q == S_STALL) || haz;
    assign stall_f      = stall_active;
    assign stall_d      = stall_active;
    assign flush_e      = stall_active;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (haz && (LOAD_LAT > 1)) begin
                    state_d = S_STALL;
                    cnt_d   = CNT_INIT;
                end
            end
            S_STALL: begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A flushed EXECUTE slot enters MEM as a bubble.
    always_comb begin
        rd_m_d       = rd_e;
        regwrite_m_d = regwrite_e && !flush_e;
        memread_m_d  = memread_e && !flush_e;
        rd_w_d       = rd_m_q;
        regwrite_w_d = regwrite_m_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_m_q       <= '0;
            regwrite_m_q <= 1'b0;
            memread_m_q  <= 1'b0;
            rd_w_q       <= '0;
            regwrite_w_q <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
        end else begin
            rd_m_q       <= rd_m_d;
            regwrite_m_q <= regwrite_m_d;
            memread_m_q  <= memread_m_d;
            rd_w_q       <= rd_w_d;
            regwrite_w_q <= regwrite_w_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] fwd_cnt_q, fwd_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating event counters.
    always_comb begin
        fwd_cnt_d   = fwd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((|fwd_sel_e) && (fwd_cnt_q != 32'hFFFF_FFFF)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
        if (stall_f && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fwd_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            fwd_cnt_q   <= fwd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fwd_count   = fwd_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign fwd_count   = 32'h0;
    assign stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// tb/tb_operand_forward_unit.sv - directed self-checking bench for operand_forward_unit

module tb_operand_forward_unit;

    logic        clk;
    logic        rst_n;
    logic [9:0]  rs_addr_d;
    logic [9:0]  rs_addr_e;
    logic [63:0] rf_data_e;
    logic [4:0]  rd_e;
    logic        regwrite_e;
    logic        memread_e;
    logic [31:0] fu_result_m;
    logic [31:0] result_w;

    logic [63:0] operand_e;
    logic [3:0]  fwd_sel_e;
    logic        stall_f, stall_d, flush_e;
    logic [31:0] fwd_count, stall_count;

    logic [63:0] operand_e3;
    logic [3:0]  fwd_sel_e3;
    logic        stall_f3, stall_d3, flush_e3;
    logic [31:0] fwd_count3, stall_count3;

    int n_vec = 0;
    int n_err = 0;

    operand_forward_unit #(.XLEN(32), .NUM_SRC(2), .REG_AW(5), .LOAD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .rs_addr_d(rs_addr_d), .rs_addr_e(rs_addr_e),
        .rf_data_e(rf_data_e), .rd_e(rd_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
        .fu_result_m(fu_result_m), .result_w(result_w), .operand_e(operand_e),
        .fwd_sel_e(fwd_sel_e), .stall_f(stall_f), .stall_d(stall_d), .flush_e(flush_e),
        .fwd_count(fwd_count), .stall_count(stall_count)
    );

    operand_forward_unit #(.XLEN(32), .NUM_SRC(2), .REG_AW(5), .LOAD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .rs_addr_d(rs_addr_d), .rs_addr_e(rs_addr_e),
        .rf_data_e(rf_data_e), .rd_e(rd_e), .regwrite_e(regwrite_e), .memread_e(memread_e),
        .fu_result_m(fu_result_m), .result_w(result_w), .operand_e(operand_e3),
        .fwd_sel_e(fwd_sel_e3), .stall_f(stall_f3), .stall_d(stall_d3), .flush_e(flush_e3),
        .fwd_count(fwd_count3), .stall_count(stall_count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        rs_addr_d   = '0;
        rs_addr_e   = {5'd5, 5'd5};
        rf_data_e   = {32'h2222_2222, 32'h1111_1111};
        rd_e        = 5'd5;
        regwrite_e  = 1'b1;
        memread_e   = 1'b0;
        fu_result_m = 32'h0BAD_0BAD;
        result_w    = 32'h0BAD_0BAD;
        step();
        step();
        regwrite_e = 1'b0;
        #1;
        n_vec++;
        if (fwd_sel_e !== 4'b0000) begin
            n_err++; $display("FAIL reset_fwd_sel got=%b exp=%b", fwd_sel_e, 4'b0000);
        end
        n_vec++;
        if (operand_e !== 64'h2222_2222_1111_1111) begin
            n_err++; $display("FAIL reset_operand got=%h exp=%h", operand_e, 64'h2222_2222_1111_1111);
        end
        n_vec++;
        if ({stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3} !== 6'b000000) begin
            n_err++; $display("FAIL reset_stall got=%b exp=%b",
                              {stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3}, 6'b0);
        end
        n_vec++;
        if ({fwd_count, stall_count} !== 64'h0) begin
            n_err++; $display("FAIL reset_counters got=%h exp=%h", {fwd_count, stall_count}, 64'h0);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_mem_wb_forward();
        regwrite_e = 1'b1;
        rd_e       = 5'd5;
        step();
        regwrite_e  = 1'b0;
        rd_e        = 5'd0;
        rs_addr_e   = {5'd6, 5'd5};
        fu_result_m = 32'hDEAD_BEEF;
        result_w    = 32'h0000_0000;
        #1;
        n_vec++;
        if (fwd_sel_e !== 4'b0010) begin
            n_err++; $display("FAIL mem_fwd_sel got=%b exp=%b", fwd_sel_e, 4'b0010);
        end
        n_vec++;
        if (operand_e !== 64'h2222_2222_DEAD_BEEF) begin
            n_err++; $display("FAIL mem_fwd_operand got=%h exp=%h", operand_e, 64'h2222_2222_DEAD_BEEF);
        end
        step();
        result_w  = 32'hCAFE_0001;
        rs_addr_e = {5'd5, 5'd5};
        #1;
        n_vec++;
        if (fwd_sel_e !== 4'b0101) begin
            n_err++; $display("FAIL wb_fwd_both_sel got=%b exp=%b", fwd_sel_e, 4'b0101);
        end
        n_vec++;
        if (operand_e !== 64'hCAFE_0001_CAFE_0001) begin
            n_err++; $display("FAIL wb_fwd_both_operand got=%h exp=%h", operand_e, 64'hCAFE_0001_CAFE_0001);
        end
        step();
        #1;
        n_vec++;
        if (fwd_sel_e !== 4'b0000) begin
            n_err++; $display("FAIL fwd_retired_sel got=%b exp=%b", fwd_sel_e, 4'b0000);
        end
    endtask

    task automatic test_priority();
        regwrite_e = 1'b1;
        rd_e       = 5'd7;
        step();
        step();
        regwrite_e  = 1'b0;
        rd_e        = 5'd0;
        rs_addr_e   = {5'd7, 5'd0};
        fu_result_m = 32'h0000_0001;
        result_w    = 32'h0000_0002;
        #1;
        n_vec++;
        if (fwd_sel_e !== 4'b1000) begin
            n_err++; $display("FAIL priority_sel got=%b exp=%b", fwd_sel_e, 4'b1000);
        end
        n_vec++;
        if (operand_e !== 64'h0000_0001_1111_1111) begin
            n_err++; $display("FAIL priority_operand got=%h exp=%h", operand_e, 64'h0000_0001_1111_1111);
        end
        // x0 written in both MEM and WB must still read the register file.
        regwrite_e = 1'b1;
        rd_e       = 5'd0;
        step();
        step();
        regwrite_e = 1'b0;
        rs_addr_e  = {5'd0, 5'd0};
        #1;
        n_vec++;
        if ({fwd_sel_e, operand_e} !== {4'b0000, 64'h2222_2222_1111_1111}) begin
            n_err++; $display("FAIL x0_no_fwd got=%b/%h exp=%b/%h", fwd_sel_e, operand_e,
                              4'b0000, 64'h2222_2222_1111_1111);
        end
        step();
    endtask

    task automatic test_load_use();
        regwrite_e = 1'b1;
        memread_e  = 1'b0;
        rd_e       = 5'd9;
        rs_addr_d  = '0;
        rs_addr_e  = '0;
        step();
        // Load to x3 in EXECUTE while the older x9 writer is in MEM.
        memread_e   = 1'b1;
        regwrite_e  = 1'b1;
        rd_e        = 5'd3;
        rs_addr_d   = {5'd3, 5'd1};
        rs_addr_e   = {5'd0, 5'd9};
        fu_result_m = 32'hABCD_0123;
        #1;
        n_vec++;
        if ({stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3} !== 6'b111111) begin
            n_err++; $display("FAIL lu_detect got=%b exp=%b",
                              {stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3}, 6'b111111);
        end
        n_vec++;
        if ({fwd_sel_e, operand_e[31:0]} !== {4'b0010, 32'hABCD_0123}) begin
            n_err++; $display("FAIL lu_older_fwd got=%b/%h exp=%b/%h", fwd_sel_e, operand_e[31:0],
                              4'b0010, 32'hABCD_0123);
        end
        step();
        // EXECUTE now holds the bubble; the flushed load never reaches the MEM tags.
        memread_e  = 1'b0;
        regwrite_e = 1'b0;
        rd_e       = 5'd0;
        rs_addr_e  = {5'd3, 5'd9};
        result_w   = 32'h5555_AAAA;
        #1;
        n_vec++;
        if ({stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3} !== 6'b000111) begin
            n_err++; $display("FAIL lu_cycle2_stall got=%b exp=%b",
                              {stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3}, 6'b000111);
        end
        n_vec++;
        if ({fwd_sel_e, operand_e} !== {4'b0001, 64'h2222_2222_5555_AAAA}) begin
            n_err++; $display("FAIL lu_after_fwd got=%b/%h exp=%b/%h", fwd_sel_e, operand_e,
                              4'b0001, 64'h2222_2222_5555_AAAA);
        end
        step();
        n_vec++;
        if ({stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3} !== 6'b000111) begin
            n_err++; $display("FAIL lu_cycle3_stall got=%b exp=%b",
                              {stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3}, 6'b000111);
        end
        step();
        n_vec++;
        if ({stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3} !== 6'b000000) begin
            n_err++; $display("FAIL lu_cycle4_stall got=%b exp=%b",
                              {stall_f, stall_d, flush_e, stall_f3, stall_d3, flush_e3}, 6'b000000);
        end
`ifdef FWD_STATS_EN
        n_vec++;
        if ({stall_count, stall_count3} !== {32'd1, 32'd3}) begin
            n_err++; $display("FAIL lu_stall_count got=%0d/%0d exp=1/3", stall_count, stall_count3);
        end
`else
        n_vec++;
        if ({fwd_count, stall_count, fwd_count3, stall_count3} !== 128'h0) begin
            n_err++; $display("FAIL stats_tied_off got=%h/%h exp=0/0", fwd_count, stall_count3);
        end
`endif
    endtask

    task automatic test_reset_mid_stall();
        memread_e  = 1'b1;
        regwrite_e = 1'b1;
        rd_e       = 5'd3;
        rs_addr_d  = {5'd3, 5'd1};
        step();
        memread_e  = 1'b0;
        regwrite_e = 1'b0;
        rd_e       = 5'd0;
        step();
        // Second STALL cycle of the LOAD_LAT=3 instance.
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({stall_f3, stall_d3, flush_e3} !== 3'b111) begin
            n_err++; $display("FAIL rst_stall_before got=%b exp=%b", {stall_f3, stall_d3, flush_e3}, 3'b111);
        end
        step();
        n_vec++;
        if ({stall_f3, stall_d3, flush_e3} !== 3'b000) begin
            n_err++; $display("FAIL rst_stall_after got=%b exp=%b", {stall_f3, stall_d3, flush_e3}, 3'b000);
        end
        n_vec++;
        if ({fwd_count, stall_count, fwd_count3, stall_count3} !== 128'h0) begin
            n_err++; $display("FAIL rst_counters got=%h/%h exp=0/0", stall_count, stall_count3);
        end
        rst_n = 1'b1;
        step();
        n_vec++;
        if ({stall_f3, stall_d3, flush_e3} !== 3'b000) begin
            n_err++; $display("FAIL rst_fsm_idle got=%b exp=%b", {stall_f3, stall_d3, flush_e3}, 3'b000);
        end
    endtask

`ifdef FWD_STATS_EN
    task automatic test_saturation();
        rs_addr_d  = '0;
        memread_e  = 1'b0;
        regwrite_e = 1'b1;
        rd_e       = 5'd4;
        step();
        rs_addr_e = {5'd0, 5'd4};
        #1;
        force dut.fwd_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.fwd_cnt_q;
        step();
        n_vec++;
        if (fwd_count !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL sat_reach got=%h exp=%h", fwd_count, 32'hFFFF_FFFF);
        end
        step();
        step();
        n_vec++;
        if (fwd_count !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL sat_hold got=%h exp=%h", fwd_count, 32'hFFFF_FFFF);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_mem_wb_forward();
        test_priority();
        test_load_use();
        test_reset_mid_stall();
`ifdef FWD_STATS_EN
        test_saturation();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
